// File: rtl/univ_shift_unit.sv
// rtl/univ_shift_unit.sv - universal shift register with multi-cycle shift/rotate sequencer
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   load, d      parallel load request and data (IDLE only, wins over start)
//   start        shift request (IDLE only); latches mode and amt
//   mode         000 SHL, 001 SHR, 010 SRA, 011 ROL, 100 ROR, others reserved (no-op)
//   amt          number of single-bit shifts, 0 completes immediately
//   sin_l, sin_r live fill bits for SHR / SHL
//   q            register contents
//   busy, done   decodes of the SHIFT and DONE states
//   sout         bit shifted out by the most recent single-bit shift
module univ_shift_unit #(
    parameter int N  = 8,
    parameter int SW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [N-1:0]  d,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [SW-1:0] amt,
    input  logic          sin_l,
    input  logic          sin_r,
    output logic [N-1:0]  q,
    output logic          busy,
    output logic          done,
    output logic          sout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [2:0]    mode_r;
    logic [SW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            q      <= '0;
            sout   <= 1'b0;
            cnt    <= '0;
            mode_r <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        q <= d;
                    end else if (start) begin
                        mode_r <= mode;
                        cnt    <= amt;
                        state  <= (amt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    // Fill bits are taken live on every shift edge, not at start.
                    case (mode_r)
                        3'b000: begin q <= {q[N-2:0], sin_r}; sout <= q[N-1]; end
                        3'b001: begin q <= {sin_l, q[N-1:1]}; sout <= q[0];   end
                        3'b010: begin q <= {q[N-1], q[N-1:1]}; sout <= q[0];  end
                        3'b011: begin q <= {q[N-2:0], q[N-1]}; sout <= q[N-1]; end
                        3'b100: begin q <= {q[0], q[N-1:1]}; sout <= q[0];    end
                        default: ; // reserved: count down without touching q/sout
                    endcase
                    cnt <= cnt - SW'(1);
                    if (cnt == SW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_univ_shift_unit.sv
// tb/tb_univ_shift_unit.sv - self-checking bench for univ_shift_unit
module tb_univ_shift_unit;

    localparam int N  = 8;
    localparam int SW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [N-1:0]  d;
    logic          start;
    logic [2:0]    mode;
    logic [SW-1:0] amt;
    logic          sin_l;
    logic          sin_r;
    logic [N-1:0]  q;
    logic          busy;
    logic          done;
    logic          sout;

    int checks = 0;
    int errors = 0;

    univ_shift_unit #(.N(N), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .d     (d),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .q     (q),
        .busy  (busy),
        .done  (done),
        .sout  (sout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: "remaining shifts" count plus a done flag.
    logic [N-1:0] mq    = '0;
    logic         msout = 1'b0;
    int           mrem  = 0;
    logic         mdone = 1'b0;
    logic [2:0]   mmode = 3'b000;
    logic         cmp_en = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            mq = '0; msout = 1'b0; mrem = 0; mdone = 1'b0;
        end else if (mdone) begin
            mdone = 1'b0;
        end else if (mrem > 0) begin
            case (mmode)
                3'd0: begin msout = mq[N-1]; mq = N'((mq << 1) | N'(sin_r)); end
                3'd1: begin msout = mq[0];   mq = N'((mq >> 1) | (N'(sin_l) << (N-1))); end
                3'd2: begin msout = mq[0];   mq = N'($signed(mq) >>> 1); end
                3'd3: begin msout = mq[N-1]; mq = N'((mq << 1) | (mq >> (N-1))); end
                3'd4: begin msout = mq[0];   mq = N'((mq >> 1) | (mq << (N-1))); end
                default: ;
            endcase
            mrem = mrem - 1;
            if (mrem == 0) mdone = 1'b1;
        end else if (load) begin
            mq = d;
        end else if (start) begin
            mmode = mode;
            mrem  = int'(amt);
            if (amt == '0) mdone = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_q",    32'(q),    32'(mq));
            chk("model_sout", 32'(sout), 32'(msout));
            chk("model_busy", 32'(busy), 32'(mrem > 0));
            chk("model_done", 32'(done), 32'(mdone));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [N-1:0] v);
        load = 1'b1; d = v;
        step();
        load = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] m, input logic [SW-1:0] a);
        start = 1'b1; mode = m; amt = a;
        step();
        start = 1'b0;
    endtask

    int ndone;
    logic [N-1:0] q_at_done;
    logic sout_at_done;

    initial begin
        reset = 1'b0; load = 1'b1; d = 8'hFF; start = 1'b1;
        mode = 3'd0; amt = 4'd3; sin_l = 1'b0; sin_r = 1'b1;
        step(); step(); step();
        // reset held low: load/start have no effect
        chk("reset_q",    32'(q),    32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_sout", 32'(sout), 32'h0);
        load = 1'b0; start = 1'b0; sin_r = 1'b0;
        reset = 1'b1;
        cmp_en = 1'b1;
        step();

        // Load 0xA5
        do_load(8'hA5);
        chk("load_q",    32'(q),    32'hA5);
        chk("load_busy", 32'(busy), 32'h0);
        chk("load_done", 32'(done), 32'h0);

        // load wins over start
        load = 1'b1; d = 8'h3E; start = 1'b1; mode = 3'd0; amt = 4'd2;
        step();
        load = 1'b0; start = 1'b0;
        chk("loadwin_q",    32'(q),    32'h3E);
        chk("loadwin_busy", 32'(busy), 32'h0);

        // ROL 0x81 by 3
        do_load(8'h81);
        do_start(3'd3, 4'd3);
        for (int i = 0; i < 3; i++) begin
            chk("rol_busy", 32'(busy), 32'h1);
            step();
        end
        chk("rol_done", 32'(done), 32'h1);
        chk("rol_q",    32'(q),    32'h0C);
        chk("rol_sout", 32'(sout), 32'h0);
        step();
        chk("rol_done_clr", 32'(done), 32'h0);

        // SRA 0x90 by 2
        do_load(8'h90);
        do_start(3'd2, 4'd2);
        step();
        step();
        chk("sra_done", 32'(done), 32'h1);
        chk("sra_q",    32'(q),    32'hE4);
        chk("sra_sout", 32'(sout), 32'h0);
        step();

        // SHL by 9 from 0 with sin_r=1, extra start/load during busy
        do_load(8'h00);
        sin_r = 1'b1;
        do_start(3'd0, 4'd9);
        start = 1'b1; load = 1'b1; d = 8'h55; amt = 4'd1;
        step();
        start = 1'b0; load = 1'b0;
        ndone = 0; q_at_done = '0; sout_at_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (done) begin
                ndone++;
                q_at_done = q;
                sout_at_done = sout;
            end
            step();
        end
        chk("shl9_ndone", 32'(ndone),        32'd1);
        chk("shl9_q",     32'(q_at_done),    32'hFF);
        chk("shl9_sout",  32'(sout_at_done), 32'h1);
        sin_r = 1'b0;

        // SHR with live sin_l toggling
        do_load(8'h0F);
        do_start(3'd1, 4'd4);
        for (int i = 0; i < 4; i++) begin
            sin_l = ~sin_l;
            step();
        end
        chk("shr_done", 32'(done), 32'h1);
        chk("shr_q",    32'(q),    32'h50);
        step();
        sin_l = 1'b0;

        // Reserved mode: q and sout unchanged, still completes
        do_load(8'h5A);
        do_start(3'd6, 4'd2);
        step(); step();
        chk("rsv_done", 32'(done), 32'h1);
        chk("rsv_q",    32'(q),    32'h5A);
        step();

        // Zero amount
        do_load(8'h3C);
        do_start(3'd4, 4'd0);
        chk("zero_done", 32'(done), 32'h1);
        chk("zero_busy", 32'(busy), 32'h0);
        chk("zero_q",    32'(q),    32'h3C);
        step();

        // Mid-operation reset during ROR by 6
        do_load(8'hB7);
        do_start(3'd4, 4'd6);
        step(); step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_q",    32'(q),    32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        do_load(8'h42);
        chk("abort_load_q", 32'(q), 32'h42);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            step();
        end
        chk("abort_ndone", 32'(ndone), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_unit.md
UNIV_SHIFT_UNIT -- requirements
Module: univ_shift_unit

Interface
REQ-001 Parameter N, default 8, register width, legal range N >= 2.
REQ-002 Parameter SW, default $clog2(N)+1, width of the shift-amount field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 load  input  1  parallel-load request, honoured only in IDLE.
REQ-006 d  input  N  parallel-load data.
REQ-007 start  input  1  shift-operation request, honoured only in IDLE.
REQ-008 mode  input  3  operation: 000 SHL, 001 SHR, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved.
REQ-009 amt  input  SW  number of single-bit shifts; unsigned, 0..2^SW-1.
REQ-010 sin_l  input  1  fill bit entering at bit N-1 for SHR.
REQ-011 sin_r  input  1  fill bit entering at bit 0 for SHL.
REQ-012 q  output  N  register contents.
REQ-013 busy  output  1  high while in SHIFT.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 sout  output  1  bit shifted out by the most recent single-bit shift.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-017 In IDLE, load=1 SHALL set q<=d at the next edge, with the state remaining IDLE.
REQ-018 In IDLE, start=1 with load=0 SHALL latch mode and amt internally.
REQ-019 On that start, the next state SHALL be SHIFT when amt>0, and DONE when amt=0.
REQ-020 When load and start are both 1 in IDLE, load SHALL win and start SHALL be ignored.
REQ-021 In SHIFT, each edge SHALL apply one single-bit shift of the latched mode to q and decrement the counter.
REQ-022 In SHIFT, the edge at which the counter equals 1 SHALL move the state to DONE.
REQ-023 Single-bit shift definitions: SHL q<={q[N-2:0],sin_r}, sout<=q[N-1].
REQ-024 SHR q<={sin_l,q[N-1:1]}, sout<=q[0].
REQ-025 SRA q<={q[N-1],q[N-1:1]}, sout<=q[0].
REQ-026 ROL q<={q[N-2:0],q[N-1]}, sout<=q[N-1].
REQ-027 ROR q<={q[0],q[N-1:1]}, sout<=q[0].
REQ-028 Reserved modes SHALL leave q and sout unchanged while still counting and completing normally.
REQ-029 sin_l and sin_r SHALL be sampled live on each shift edge, not latched at start.
REQ-030 amt>N SHALL be legal: logical shifts continue filling, and rotates wrap naturally (no modulo is applied to amt).
REQ-031 busy SHALL equal (state==SHIFT), and done SHALL equal (state==DONE); both are registered-state decodes.
REQ-032 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-033 Latency: start sampled at edge k gives done high in the cycle after edge k+amt (amt=0: after edge k).
REQ-034 In SHIFT and DONE, start, load, mode and amt SHALL be ignored, and no request is queued.
REQ-035 sout SHALL hold its value when no shift occurs.

Reset
REQ-036 reset=0 at a rising edge SHALL force q=0, sout=0, counter=0 and state IDLE, giving busy=0 and done=0.
REQ-037 Reset SHALL take priority over every other input, including mid-SHIFT; the aborted operation produces no done.
REQ-038 While reset is held low, load and start SHALL have no effect.

Verification
REQ-039 Load: N=8, load=1, d=0xA5 -> q=0xA5 after one edge, busy=0, done=0.
REQ-040 Rotate: q=0x81, start, ROL, amt=3 -> busy high 3 cycles, then done pulse with q=0x0C, sout=0.
REQ-041 Arithmetic shift: q=0x90, start, SRA, amt=2 -> q=0xE4, sout=0, done after 3 edges.
REQ-042 Over-length shift: q=0x00, sin_r=1, SHL, amt=9 -> q=0xFF, sout=1; a start pulse during busy is ignored, with exactly one done.
REQ-043 Zero amount: q=0x3C, start, amt=0 -> done on the cycle after start, busy never high, q=0x3C.
REQ-044 Mid-operation reset: ROR amt=6, reset=0 after 2 shifts -> q=0x00, busy=0, no done, IDLE accepts a new load next cycle.
